// File: rtl/rv_pkg.sv
// Shared definitions for the integer register file slice.
//   XLEN  : default data width of an architectural register
//   NREGS : default number of architectural registers (power of two, >= 2)
//   AW    : register address width derived from NREGS
//   state_t : init-sweep FSM encoding (ST_INIT = 0, ST_RUN = 1)
package rv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage : rv_pkg

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard used for RAW hazard detection.
// One busy flop per architectural register. Priority per entry, high to low:
// flush clears everything, issue sets busy[iss_rd], writeback clears busy[wb_rd].
// Ports:
//   clk, reset          clock and synchronous active-high reset (clears all busy bits)
//   iss_valid, iss_rd   issued instruction will write iss_rd -> mark it busy
//   wb_valid, wb_rd     writeback retires the outstanding writer of wb_rd
//   flush               clear every busy bit
//   rd1_addr, rd1_busy  lookup port 1 (same-cycle writeback hides the hazard)
//   rd2_addr, rd2_busy  lookup port 2
module reg_scoreboard #(
  parameter int  NREGS    = rv_pkg::NREGS,
  parameter int  ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_rd,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_rd,
  input  logic          flush,
  input  logic [AW-1:0] rd1_addr,
  output logic          rd1_busy,
  input  logic [AW-1:0] rd2_addr,
  output logic          rd2_busy
);

  logic [NREGS-1:0] busy_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_busy
      // Entry 0 can never become busy when it is the hardwired zero register.
      localparam bit TRACKED = (ZERO_REG == 0) || (gi != 0);

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          busy_reg[gi] <= 1'b0;
        end else if (TRACKED && iss_valid && (iss_rd == AW'(gi))) begin
          // Issue wins over a same-cycle writeback: the new instruction owns it.
          busy_reg[gi] <= 1'b1;
        end else if (wb_valid && (wb_rd == AW'(gi))) begin
          busy_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // A writeback in the current cycle is already visible through the data
  // bypass, so the hazard it resolves is masked combinationally.
  assign rd1_busy = busy_reg[rd1_addr] & ~(wb_valid && (wb_rd == rd1_addr));
  assign rd2_busy = busy_reg[rd2_addr] & ~(wb_valid && (wb_rd == rd2_addr));

endmodule : reg_scoreboard

// File: rtl/regfile_scoreboard.sv
// Integer register file for the pipelined core: two combinational read ports
// with write-to-read bypass, one write port, optional hardwired x0, and a busy
// scoreboard. After reset an init FSM clears one entry per cycle; ports are
// inert (reads 0, writes/issue/flush ignored) until ready is high.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ready                      init sweep finished, ports live
//   rs1_addr/rs1_data/rs1_busy read port 1 address, data, hazard flag
//   rs2_addr/rs2_data/rs2_busy read port 2 address, data, hazard flag
//   we, wr_addr, wr_data       writeback port
//   iss_valid, iss_rd          issue of an instruction writing iss_rd
//   flush                      clear all busy bits
module regfile_scoreboard #(
  parameter int  XLEN     = rv_pkg::XLEN,
  parameter int  NREGS    = rv_pkg::NREGS,
  parameter int  ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ready,
  input  logic [AW-1:0]   rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic            rs1_busy,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs2_busy,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush
);

  import rv_pkg::*;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  // ---------------------------------------------------------------- init FSM
  state_t        state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic          ready_reg, ready_next;
  logic          run;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ready_reg <= ready_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ready_next = ready_reg;
    case (state_reg)
      ST_INIT: begin
        if (cnt_reg == LAST_IDX) begin
          // Leave the counter at the last index rather than wrapping.
          state_next = ST_RUN;
          ready_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_RUN: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_INIT;
        cnt_next   = '0;
        ready_next = 1'b0;
      end
    endcase
  end

  assign run   = (state_reg == ST_RUN);
  assign ready = ready_reg;

  // ------------------------------------------------------------ storage array
  logic [XLEN-1:0] mem [NREGS];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic            wr_is_x0;

  assign wr_is_x0 = (ZERO_REG != 0) && (wr_addr == '0);

  // The sweep and the writeback port share the single array write port;
  // the FSM state decides which one owns it.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (!run) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_reg;
      mem_wdata = '0;
    end else begin
      mem_we = we && !wr_is_x0;
    end
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // --------------------------------------------------------------- read ports
  logic [AW-1:0]   rd_addr [2];
  logic [XLEN-1:0] rd_data [2];

  assign rd_addr[0] = rs1_addr;
  assign rd_addr[1] = rs2_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      // x0 check first, then same-cycle bypass, then the array.
      always_comb begin
        rd_data[gi] = '0;
        if (run && !((ZERO_REG != 0) && (rd_addr[gi] == '0))) begin
          if (we && (wr_addr == rd_addr[gi])) begin
            rd_data[gi] = wr_data;
          end else begin
            rd_data[gi] = mem[rd_addr[gi]];
          end
        end
      end
    end
  endgenerate

  assign rs1_data = rd_data[0];
  assign rs2_data = rd_data[1];

  // --------------------------------------------------------------- scoreboard
  logic sb_rd1_busy, sb_rd2_busy;

  reg_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid && run),
    .iss_rd    (iss_rd),
    .wb_valid  (we && run),
    .wb_rd     (wr_addr),
    .flush     (flush && run),
    .rd1_addr  (rs1_addr),
    .rd1_busy  (sb_rd1_busy),
    .rd2_addr  (rs2_addr),
    .rd2_busy  (sb_rd2_busy)
  );

  assign rs1_busy = sb_rd1_busy && run;
  assign rs2_busy = sb_rd2_busy && run;

endmodule : regfile_scoreboard
